adain_channel_sequencer: RTL
============================

// Module: adain_channel_sequencer
// PURPOSE
// Upstream feeder for the AdaIN core. Accepts one channel of N feature samples on a valid/ready stream.
// Buffers them locally, then replays the buffer three times into the core:
//   pass 1 = mean, pass 2 = variance, pass 3 = normalise.
// Issues the start code for each pass and holds ys/yb steady. Emits the normalised outputs as a
// valid-only stream, one channel at a time.
// PARAMETERS
// WIDTH_IN     48   sample/ys/yb width, Q(32.16), matches core input
// WIDTH_OUT    16   core output width, Q(8.8)
// N_MAX        128  max samples per channel; buffer depth
// OUT_LATENCY  4    cycles from adain_in beat (pass 3) to matching adain_out valid
// TIMEOUT      1024 max cycles waiting for adain_done before abort
// PORTS
// clk          in   1                  rising-edge clock
// rst          in   1                  asynchronous, active-low reset
// cfg_n        in   $clog2(N_MAX+1)    channel length; sampled with first accepted beat
// cfg_ys       in   WIDTH_IN           style scale; sampled with first accepted beat
// cfg_yb       in   WIDTH_IN           style bias; sampled with first accepted beat
// s_valid      in   1                  input sample valid
// s_ready      out  1                  sequencer can accept a sample
// s_data       in   WIDTH_IN           input sample
// adain_start  out  2                  pass code to core: 0 = none, 1/2/3 = pass; one-cycle pulse
// adain_n      out  $clog2(N_MAX+1)    latched N to core
// adain_in     out  WIDTH_IN           replayed sample to core
// adain_ys     out  WIDTH_IN           latched ys
// adain_yb     out  WIDTH_IN           latched yb
// adain_out    in   WIDTH_OUT          core result
// adain_done   in   2                  core echoes pass code for 1 cycle at end of pass
// m_valid      out  1                  output sample valid; no backpressure, sink must accept
// m_data       out  WIDTH_OUT          normalised sample
// busy         out  1                  high from first accepted beat until channel complete/abort
// err          out  1                  one-cycle pulse on bad cfg_n or done timeout
// BEHAVIOUR
// - Reset: all outputs 0; s_ready 0; state IDLE; counters, latency pipe and latched cfg cleared.
//   Reset asserted mid-pass aborts immediately; buffer contents are don't-care afterwards.
// - States: IDLE -> LOAD -> ISSUE -> STREAM -> WAIT -> (ISSUE next pass | DRAIN) -> IDLE.
// - IDLE: s_ready=1.
//   - On s_valid: if cfg_n==0 or cfg_n>N_MAX, pulse err, drop the beat, stay IDLE.
//   - Otherwise latch cfg_n/ys/yb, write beat to addr 0, wr_cnt=1, busy=1. Go LOAD, or ISSUE if cfg_n==1.
// - LOAD: s_ready=1; each handshake writes addr wr_cnt, then increments. After beat N-1 -> ISSUE.
// - ISSUE: drive adain_start=pass for exactly 1 cycle, s_ready=0, rd_cnt=0 -> STREAM.
// - STREAM: one buffer word per cycle on adain_in, addresses 0..N-1, no gaps.
//   - Buffer read is 1-cycle, so adain_in for addr k appears the cycle after ISSUE+k.
//   - adain_in is held 0 outside STREAM beats. After the N-th beat -> WAIT.
// - WAIT: watchdog counts cycles.
//   - adain_done==pass: pass<3 -> pass+1, go ISSUE; pass==3 -> go DRAIN.
//   - adain_done other nonzero value is ignored.
//   - Watchdog reaches TIMEOUT: pulse err, clear busy -> IDLE.
// - Output capture (pass 3 only): each adain_in beat pushes a 1 into an OUT_LATENCY-deep valid pipe.
//   Pipe head drives m_valid, and m_data=adain_out on that cycle. Exactly N m_valid pulses per channel.
// - DRAIN: wait until the valid pipe is empty, then busy=0 -> IDLE.
//   A new channel may be accepted the next cycle.
// - Simultaneous done and timeout on the same cycle: done wins.
// - ys/yb/n stay stable on the core ports from latch until the next channel latch.
// STRUCTURE
// - adain_pkg: pass codes PASS_NONE/MEAN/VAR/NORM = 2'd0..3 and the state enum encoding.
// - One sub-module, sample_buffer: simple dual-port RAM, N_MAX x WIDTH_IN.
//   Synchronous write, 1-cycle registered read.
// - Top level holds the FSM, the wr/rd/watchdog counters and the valid pipe.
// TESTING
// - N=4, samples 1.0,2.0,3.0,4.0, ys=1.0, yb=0. Required:
//   - s_ready drops after 4 beats.
//   - start pulses 1,2,3 each followed by 4 adain_in beats 0x10000..0x40000.
//   - 4 m_valid pulses.
// - N=1 single beat: LOAD skipped. Each pass has 1 adain_in beat; exactly 1 m_valid.
// - cfg_n=0 and cfg_n=129: err pulses 1 cycle, busy stays 0, no adain_start.
// - Withhold adain_done in pass 2 for TIMEOUT cycles: err pulse at cycle 1024 of WAIT, busy=0, IDLE.
// - Assert rst during pass 3 beat 2: all outputs 0 next edge.
//   Following channel with N=2 completes normally.
// - Back-to-back channels N=128: first beat of channel 2 accepted the cycle after busy falls.
//   256 total m_valid.

Source files
------------

// File: rtl/adain_channel_sequencer_pkg.sv
// Shared widths, pass codes and FSM encoding for the AdaIN channel sequencer.
package adain_channel_sequencer_pkg;

  localparam int WIDTH_IN    = 48;
  localparam int WIDTH_OUT   = 16;
  localparam int N_MAX       = 128;
  localparam int OUT_LATENCY = 4;
  localparam int TIMEOUT     = 1024;

  localparam int N_W    = $clog2(N_MAX + 1);
  localparam int ADDR_W = $clog2(N_MAX);
  localparam int WD_W   = $clog2(TIMEOUT);

  localparam logic [N_W-1:0] N_MAX_N = N_W'(N_MAX);

  typedef enum logic [1:0] {
    PASS_NONE = 2'd0,
    PASS_MEAN = 2'd1,
    PASS_VAR  = 2'd2,
    PASS_NORM = 2'd3
  } pass_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_ISSUE  = 3'd2,
    ST_STREAM = 3'd3,
    ST_WAIT   = 3'd4,
    ST_DRAIN  = 3'd5
  } state_e;

  function automatic logic cfg_ok(input logic [N_W-1:0] n);
    return (n != '0) && (n <= N_MAX_N);
  endfunction

endpackage

// File: rtl/adain_channel_sequencer_if.sv
// Bus bundle between the sequencer, its sample source, the AdaIN core and the result sink.
interface adain_channel_sequencer_if;
  import adain_channel_sequencer_pkg::*;

  logic [N_W-1:0]       cfg_n;
  logic [WIDTH_IN-1:0]  cfg_ys;
  logic [WIDTH_IN-1:0]  cfg_yb;
  logic                 s_valid;
  logic                 s_ready;
  logic [WIDTH_IN-1:0]  s_data;
  logic [1:0]           adain_start;
  logic [N_W-1:0]       adain_n;
  logic [WIDTH_IN-1:0]  adain_in;
  logic [WIDTH_IN-1:0]  adain_ys;
  logic [WIDTH_IN-1:0]  adain_yb;
  logic [WIDTH_OUT-1:0] adain_out;
  logic [1:0]           adain_done;
  logic                 m_valid;
  logic [WIDTH_OUT-1:0] m_data;

  modport master (
    input  cfg_n, cfg_ys, cfg_yb, s_valid, s_data, adain_out, adain_done,
    output s_ready, adain_start, adain_n, adain_in, adain_ys, adain_yb, m_valid, m_data
  );

  modport slave (
    output cfg_n, cfg_ys, cfg_yb, s_valid, s_data, adain_out, adain_done,
    input  s_ready, adain_start, adain_n, adain_in, adain_ys, adain_yb, m_valid, m_data
  );

endinterface

// File: rtl/adain_channel_sequencer_sample_buffer.sv
// Channel sample store: synchronous write, registered read that returns 0 when not reading.
module adain_channel_sequencer_sample_buffer
  import adain_channel_sequencer_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic [ADDR_W-1:0]   waddr,
  input  logic [WIDTH_IN-1:0] wdata,
  input  logic                re,
  input  logic [ADDR_W-1:0]   raddr,
  output logic [WIDTH_IN-1:0] rdata
);

  logic [WIDTH_IN-1:0] mem [N_MAX];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Zero outside reads so the core port idles at 0 between replay beats.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rdata <= '0;
    else      rdata <= re ? mem[raddr] : '0;
  end

endmodule

// File: rtl/adain_channel_sequencer.sv
// Buffers one channel, replays it three times (mean, variance, normalise) into the AdaIN core.
// state  | meaning
// IDLE   | ready for the first beat of a channel
// LOAD   | collecting the remaining beats into the buffer
// ISSUE  | one-cycle start pulse for the current pass, first read issued
// STREAM | one replayed sample per cycle on adain_in
// WAIT   | waiting for the core to echo the pass code, watchdog running
// DRAIN  | letting the last normalised outputs leave the valid pipe
module adain_channel_sequencer
  import adain_channel_sequencer_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  adain_channel_sequencer_if.master bus,
  output logic                      busy,
  output logic                      err
);

  state_e               state;
  pass_e                pass;
  logic [N_W-1:0]       n_q;
  logic [N_W-1:0]       wr_cnt;
  logic [N_W-1:0]       rd_cnt;
  logic [WD_W-1:0]      wd_cnt;
  logic [WIDTH_IN-1:0]  ys_q;
  logic [WIDTH_IN-1:0]  yb_q;
  logic [1:0]           start_q;
  logic                 s_ready_q;
  logic [OUT_LATENCY-1:0] vpipe;

  logic                 accept;
  logic                 we;
  logic                 re;
  logic [ADDR_W-1:0]    waddr;
  logic [ADDR_W-1:0]    raddr;
  logic [WIDTH_IN-1:0]  rd_data;

  assign accept = bus.s_valid && s_ready_q;
  assign we     = accept && (((state == ST_IDLE) && cfg_ok(bus.cfg_n)) || (state == ST_LOAD));
  assign waddr  = (state == ST_LOAD) ? wr_cnt[ADDR_W-1:0] : '0;
  assign re     = (state == ST_ISSUE) || ((state == ST_STREAM) && (rd_cnt < n_q));
  assign raddr  = (state == ST_STREAM) ? rd_cnt[ADDR_W-1:0] : '0;

  adain_channel_sequencer_sample_buffer u_buf (
    .clk   (clk),
    .rst   (rst),
    .we    (we),
    .waddr (waddr),
    .wdata (bus.s_data),
    .re    (re),
    .raddr (raddr),
    .rdata (rd_data)
  );

  assign bus.s_ready     = s_ready_q;
  assign bus.adain_start = start_q;
  assign bus.adain_n     = n_q;
  assign bus.adain_in    = rd_data;
  assign bus.adain_ys    = ys_q;
  assign bus.adain_yb    = yb_q;
  assign bus.m_valid     = vpipe[OUT_LATENCY-1];
  assign bus.m_data      = vpipe[OUT_LATENCY-1] ? bus.adain_out : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      pass      <= PASS_NONE;
      n_q       <= '0;
      wr_cnt    <= '0;
      rd_cnt    <= '0;
      wd_cnt    <= '0;
      ys_q      <= '0;
      yb_q      <= '0;
      start_q   <= PASS_NONE;
      s_ready_q <= 1'b0;
      vpipe     <= '0;
      busy      <= 1'b0;
      err       <= 1'b0;
    end else begin
      start_q <= PASS_NONE;
      err     <= 1'b0;
      // Every STREAM cycle is exactly one adain_in beat; only pass 3 produces results.
      vpipe   <= {vpipe[OUT_LATENCY-2:0], (state == ST_STREAM) && (pass == PASS_NORM)};
      case (state)
        ST_IDLE: begin
          s_ready_q <= 1'b1;
          if (accept) begin
            if (!cfg_ok(bus.cfg_n)) begin
              err <= 1'b1;
            end else begin
              n_q    <= bus.cfg_n;
              ys_q   <= bus.cfg_ys;
              yb_q   <= bus.cfg_yb;
              wr_cnt <= N_W'(1);
              busy   <= 1'b1;
              pass   <= PASS_MEAN;
              if (bus.cfg_n == N_W'(1)) begin
                s_ready_q <= 1'b0;
                start_q   <= PASS_MEAN;
                state     <= ST_ISSUE;
              end else begin
                state <= ST_LOAD;
              end
            end
          end
        end
        ST_LOAD: begin
          if (accept) begin
            wr_cnt <= wr_cnt + N_W'(1);
            if (wr_cnt == n_q - N_W'(1)) begin
              s_ready_q <= 1'b0;
              start_q   <= pass;
              state     <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          rd_cnt <= N_W'(1);
          state  <= ST_STREAM;
        end
        ST_STREAM: begin
          rd_cnt <= rd_cnt + N_W'(1);
          if (rd_cnt == n_q) begin
            wd_cnt <= WD_W'(TIMEOUT - 1);
            state  <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // Done is tested first so it wins over a same-cycle watchdog expiry.
          if (bus.adain_done == pass) begin
            if (pass == PASS_NORM) begin
              state <= ST_DRAIN;
            end else begin
              pass    <= pass_e'(pass + 2'd1);
              start_q <= pass + 2'd1;
              state   <= ST_ISSUE;
            end
          end else if (wd_cnt == '0) begin
            err       <= 1'b1;
            busy      <= 1'b0;
            s_ready_q <= 1'b1;
            state     <= ST_IDLE;
          end else begin
            wd_cnt <= wd_cnt - WD_W'(1);
          end
        end
        ST_DRAIN: begin
          if (vpipe == '0) begin
            busy      <= 1'b0;
            s_ready_q <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
